// File: rtl/fact_accel_mmio.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT registers,
// iterative n! for 4-bit n with an overflow gate at MAX_N.
module fact_accel_mmio #(
    parameter int MAX_N = 12,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE,
    input  logic [1:0]    A,
    input  logic [DW-1:0] WD,
    output logic [DW-1:0] RD
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] res_q, res_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          go, busy;

    assign go   = WE && (A == 2'd1) && WD[0];
    assign busy = (state_q == S_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = done_q;
        err_d   = err_q;
        // cnt is a private copy, so N may be rewritten mid-computation
        if (WE && (A == 2'd0)) n_d = WD[3:0];
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    if (n_q > MAX_N4) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = n_q;
                        res_d   = DW'(1);
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q > 4'd1) begin
                    res_d = res_q * DW'(cnt_q);
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        RD = '0;
        case (A)
            2'd0: RD = {{(DW-4){1'b0}}, n_q};
            2'd1: RD = {{(DW-1){1'b0}}, busy};
            2'd2: RD = {{(DW-2){1'b0}}, err_q, done_q};
            2'd3: RD = res_q;
            default: RD = '0;
        endcase
    end
endmodule

// File: tb/tb_fact_accel_mmio.sv
// Bench for fact_accel_mmio: latency/result model checked every cycle plus
// directed literal checks from hand-computed values.
module tb_fact_accel_mmio;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          WE  = 1'b0;
    logic [1:0]    A   = 2'd0;
    logic [DW-1:0] WD  = '0;
    logic [DW-1:0] RD;

    int ncheck = 0;
    int nfail  = 0;

    fact_accel_mmio #(.MAX_N(12), .DW(DW)) dut (
        .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD), .RD(RD)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] f = 32'd1;
        for (int i = 2; i <= n; i++) f = f * 32'(i);
        return f;
    endfunction

    // Model: a started computation stays busy for max(n,1) cycles, then shows n!
    int          m_n, m_sn, m_left;
    bit          m_done, m_err;
    logic [31:0] m_res;

    initial begin
        bit was_busy;
        m_n = 0; m_sn = 0; m_left = 0; m_done = 0; m_err = 0; m_res = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_n = 0; m_left = 0; m_done = 0; m_err = 0; m_res = 0;
            end else begin
                was_busy = (m_left > 0);
                if (was_busy) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_done = 1;
                        m_res  = fact(m_sn);
                    end
                end
                if (WE && A == 2'd1 && WD[0] && !was_busy) begin
                    if (m_n <= 12) begin
                        m_sn = m_n; m_left = (m_n < 2) ? 1 : m_n;
                        m_done = 0; m_err = 0;
                    end else begin
                        m_res = 0; m_err = 1; m_done = 1;
                    end
                end
                if (WE && A == 2'd0) m_n = int'(WD[3:0]);
            end
        end
    end

    initial begin
        logic [31:0] exp;
        bit          skip;
        forever begin
            @(posedge clk);
            #1;
            skip = 0;
            case (A)
                2'd0: exp = 32'(m_n);
                2'd1: exp = {31'b0, m_left > 0};
                2'd2: exp = {30'b0, m_err, m_done};
                default: begin exp = m_res; skip = (m_left > 0); end
            endcase
            if (!skip) begin
                ncheck++;
                if (RD !== exp) begin
                    nfail++;
                    $display("FAIL model A=%0d: got %h expected %h at %0t", A, RD, exp, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        A = a;
        #1;
        ncheck++;
        if (RD !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, RD, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1; A = a; WD = d;
        @(negedge clk);
        WE = 1'b0; WD = '0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            A = 2'd2;
            #1;
            seen = RD[0];
        end
        ncheck++;
        if (!seen) begin
            nfail++;
            $display("FAIL %s: done not seen within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #3;
        chk("rst_N", 2'd0, 32'd0);
        chk("rst_GO", 2'd1, 32'd0);
        chk("rst_STATUS", 2'd2, 32'd0);
        chk("rst_RESULT", 2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // n=5: busy for 5 cycles after the start edge, done with 120 after that
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("n5_GO_busy", 2'd1, 32'd1);
            chk("n5_STATUS_busy", 2'd2, 32'd0);
            @(negedge clk);
        end
        chk("n5_STATUS", 2'd2, 32'd1);
        chk("n5_RESULT", 2'd3, 32'd120);
        chk("n5_GO_idle", 2'd1, 32'd0);

        for (int n = 0; n < 2; n++) begin
            wr(2'd0, 32'(n));
            wr(2'd1, 32'd1);
            chk("n01_STATUS_busy", 2'd2, 32'd0);
            chk("n01_GO", 2'd1, 32'd1);
            @(negedge clk);
            chk("n01_STATUS", 2'd2, 32'd1);
            chk("n01_RESULT", 2'd3, 32'd1);
        end

        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        repeat (11) @(negedge clk);
        chk("n12_STATUS_busy", 2'd2, 32'd0);
        @(negedge clk);
        chk("n12_STATUS", 2'd2, 32'd1);
        chk("n12_RESULT", 2'd3, 32'h1C8CFC00);

        wr(2'd0, 32'd13);
        wr(2'd1, 32'd1);
        chk("n13_STATUS", 2'd2, 32'd3);
        chk("n13_RESULT", 2'd3, 32'd0);
        chk("n13_GO", 2'd1, 32'd0);

        // rewriting N and re-issuing GO mid-computation must not disturb it
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd1);
        repeat (4) @(negedge clk);
        chk("n6_RESULT", 2'd3, 32'd720);
        chk("n6_N", 2'd0, 32'd2);
        chk("n6_STATUS", 2'd2, 32'd1);
        wr(2'd1, 32'd1);
        chk("n2_done_clr", 2'd2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("n2_RESULT", 2'd3, 32'd2);
        chk("n2_STATUS", 2'd2, 32'd1);

        wr(2'd2, 32'hFFFFFFFF);
        wr(2'd3, 32'hFFFFFFFF);
        @(negedge clk);
        WE = 1'b0; A = 2'd1; WD = 32'd1;
        @(negedge clk);
        WD = '0;
        chk("ign_STATUS", 2'd2, 32'd1);
        chk("ign_RESULT", 2'd3, 32'd2);
        chk("ign_GO", 2'd1, 32'd0);
        chk("ign_N", 2'd0, 32'd2);

        // asynchronous reset in the middle of a long computation
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        chk("arst_STATUS", 2'd2, 32'd0);
        chk("arst_RESULT", 2'd3, 32'd0);
        chk("arst_GO", 2'd1, 32'd0);
        chk("arst_N", 2'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        wait_done("n3_wait", 20);
        chk("n3_RESULT", 2'd3, 32'd6);
        chk("n3_STATUS", 2'd2, 32'd1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end
endmodule

// File: doc/fact_accel_mmio.md
Name: fact_accel_mmio

Overview:
- Memory-mapped factorial accelerator slave. It sits directly downstream of the SoC address decoder.
- Its write enable is the decoder's accelerator write strobe, asserted for addresses 0x800-0x8FF.
- Its read data feeds read-mux input 2'b10.
- It computes n! iteratively for a 4-bit n, with status and result readable over the bus.

Parameters:
- MAX_N, 12, largest n whose factorial fits in 32 bits; any larger n raises the error flag.
- DW, 32, data and result width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- WE  input  1  write strobe from the address decoder; already qualified for the 0x8xx region.
- A  input  2  word offset, from bus address bits [3:2].
- WD  input  DW  write data.
- RD  output  DW  read data; combinational function of A and the internal registers.

Behaviour:
- Register map (word offset A):
  - 0: N register; write stores WD[3:0]; read {28'b0, n_reg}.
  - 1: GO; write with WD[0]=1 requests a start; read {31'b0, busy}.
  - 2: STATUS; read {30'b0, err, done}; writes ignored.
  - 3: RESULT; read result_reg; writes ignored.
- Reset (asynchronous, immediate, including mid-computation): state=IDLE; n_reg=0, cnt=0, result_reg=0, done=0, err=0, busy=0. RD then reflects these zeros for the presented A.
- FSM states: IDLE, BUSY, DONE.
  - busy=1 only in BUSY.
  - DONE behaves as IDLE for start acceptance; it only holds done/err/result until the next start.
- Start acceptance at edge T: requires WE=1, A=1, WD[0]=1, and state IDLE or DONE.
  - If n_reg <= MAX_N: cnt<=n_reg, result_reg<=1, done<=0, err<=0, state<=BUSY.
  - If n_reg > MAX_N: result_reg<=0, err<=1, done<=1, state<=DONE. No BUSY cycles.
- BUSY, at each edge:
  - if cnt > 1: result_reg <= result_reg * cnt (low 32 bits), cnt <= cnt - 1.
  - else: state<=DONE, done<=1.
- Latency: for valid n, done=1 and the final result are visible after edge T+max(n,1). Examples: n=5 -> T+5; n=0 or n=1 -> T+1 with result 1.
- GO write while BUSY: ignored; the computation continues undisturbed.
- GO write with WD[0]=0: no effect.
- N write: accepted in any state, including BUSY. It does not affect a running computation, since cnt is a private copy.
- Simultaneous events: the start check uses the n_reg value before the current edge. A write to N and a start cannot coincide because of the single address.
- done/err remain set until the next accepted start or reset. Reading STATUS never clears them.
- No multiply overflow can occur for n <= 12. No wrap check is needed beyond the MAX_N gate.

Test Plan:
- Reset mid-BUSY (n=10, assert rst after 3 cycles) -> immediately: STATUS=0, RESULT=0, busy=0, N reads 0. After release, a start with n=3 completes normally with RESULT=6.
- Write N=5, GO=1 at edge T -> GO reads 1 during T+1..T+4. STATUS reads 0b01 from T+5 and RESULT=120. A STATUS read at T+4 returns 0.
- n=0 and n=1 -> each: done after exactly 1 cycle, RESULT=1, err=0.
- n=12 -> RESULT=479001600 (0x1C8CFC00) after 12 cycles, err=0. Then n=13 start -> next cycle STATUS=0b11, RESULT=0, busy never seen high.
- Start n=6; during BUSY write N=2 and GO=1 -> second GO ignored, RESULT=720, N reads 2. A subsequent start gives RESULT=2 and clears done on the start edge.
- Writes to A=2 and A=3 with 0xFFFFFFFF, and WE=0 with A=1, WD=1 -> no state change, no start, all reads unchanged.
